ir_prefetch_queue: RTL

Parametrised successor to the single-entry instruction register in the multicycle MIPS datapath. Buffers up to DEPTH fetched instructions, each with its PC, in a circular queue. Presents the head entry already split into decode fields (op, rs, rt, rd, shamt, funct, imm). Sits between instruction memory and the control FSM/register file; lets fetch run ahead of execute and discards prefetched words on a branch or jump.

---
 rtl/mips_pkg.sv | 24 ++
 rtl/inst_field_split.sv | 32 +++
 rtl/ir_prefetch_queue.sv | 111 +++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS instruction-format constants.
// Holds the default instruction width and the bit positions of every
// decode field in a 32-bit MIPS word. The prefetch queue and the later
// pipeline decode stage both slice instructions using these positions.
package mips_pkg;

    localparam int INST_W_DFLT = 32;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int SH_MSB  = 10;
    localparam int SH_LSB  = 6;
    localparam int FN_MSB  = 5;
    localparam int FN_LSB  = 0;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

endpackage

// File: rtl/inst_field_split.sv
// inst_field_split: purely combinational slicer of a 32-bit MIPS word.
// Ports:
//   inst        in  32  instruction word
//   inst_31_26  out  6  opcode
//   inst_25_21  out  5  rs
//   inst_20_16  out  5  rt
//   inst_15_11  out  5  rd
//   inst_10_6   out  5  shamt
//   inst_5_0    out  6  funct
//   inst_15_0   out 16  immediate (overlaps rd/shamt/funct)
module inst_field_split
    import mips_pkg::*;
(
    input  logic [INST_W_DFLT-1:0] inst,
    output logic [5:0]             inst_31_26,
    output logic [4:0]             inst_25_21,
    output logic [4:0]             inst_20_16,
    output logic [4:0]             inst_15_11,
    output logic [4:0]             inst_10_6,
    output logic [5:0]             inst_5_0,
    output logic [15:0]            inst_15_0
);

    assign inst_31_26 = inst[OP_MSB:OP_LSB];
    assign inst_25_21 = inst[RS_MSB:RS_LSB];
    assign inst_20_16 = inst[RT_MSB:RT_LSB];
    assign inst_15_11 = inst[RD_MSB:RD_LSB];
    assign inst_10_6  = inst[SH_MSB:SH_LSB];
    assign inst_5_0   = inst[FN_MSB:FN_LSB];
    assign inst_15_0  = inst[IMM_MSB:IMM_LSB];

endmodule

// File: rtl/ir_prefetch_queue.sv
// ir_prefetch_queue: DEPTH-entry circular queue of {pc, instruction} pairs
// placed between instruction memory and the control FSM. The head entry is
// presented already split into decode fields. A flush (branch/jump
// redirect) discards every queued word in one cycle.
// Ports:
//   CLK, RST_N          clock, asynchronous active-low reset
//   flush               discard all entries; wins over push and pop
//   in_valid/in_ready   fetch handshake; in_ready depends on count only
//   inst_in, pc_in      fetched word and its address
//   out_valid/out_ready consume handshake for the head entry
//   inst_31_26..inst_15_0, pc_out  head fields (stale while out_valid=0)
//   count               current occupancy
// INST_W must be 32; the field slicing is only defined for that width.
module ir_prefetch_queue
    import mips_pkg::*;
#(
    parameter  int INST_W = INST_W_DFLT,
    parameter  int PC_W   = 32,
    parameter  int DEPTH  = 4,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] inst_in,
    input  logic [PC_W-1:0]   pc_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [5:0]        inst_31_26,
    output logic [4:0]        inst_25_21,
    output logic [4:0]        inst_20_16,
    output logic [4:0]        inst_15_11,
    output logic [4:0]        inst_10_6,
    output logic [5:0]        inst_5_0,
    output logic [15:0]       inst_15_0,
    output logic [PC_W-1:0]   pc_out,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = PC_W + INST_W;

    logic [ENT_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_s;
    logic             pop_s;
    logic [ENT_W-1:0] head_s;

    assign in_ready  = (count_r != CNT_W'(DEPTH));
    assign out_valid = (count_r != {CNT_W{1'b0}});
    assign count     = count_r;

    // Flush dominates: a push or pop in the redirect cycle has no effect.
    assign push_s = in_valid & in_ready & ~flush;
    assign pop_s  = out_valid & out_ready & ~flush;

    // Entry storage; flush leaves contents untouched, only pointers move.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {ENT_W{1'b0}};
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= {pc_in, inst_in};
        end
    end

    // Read/write pointers and occupancy; DEPTH is a power of two so the
    // pointers wrap naturally on overflow.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush) begin
            rd_ptr_r <= wr_ptr_r;
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_s = mem_r[rd_ptr_r];
    assign pc_out = head_s[ENT_W-1:INST_W];

    inst_field_split u_split (
        .inst       (head_s[INST_W-1:0]),
        .inst_31_26 (inst_31_26),
        .inst_25_21 (inst_25_21),
        .inst_20_16 (inst_20_16),
        .inst_15_11 (inst_15_11),
        .inst_10_6  (inst_10_6),
        .inst_5_0   (inst_5_0),
        .inst_15_0  (inst_15_0)
    );

endmodule
